// File: rtl/image_pkg.sv
// image_pkg: shared constants and types for the image vector fetch sequencer.
//   PLANE_PIXELS / NUM_PLANES : geometry of the ROM pixel address space
//   LANES / LANE_W            : pixels per vector word and bits per pixel lane
//   IMG_SPACE                 : total addressable pixels (end-of-range check)
//   fetch_state_t             : sequencer FSM states
package image_pkg;

  localparam int PLANE_PIXELS = 10000;
  localparam int NUM_PLANES   = 12;
  localparam int LANES        = 4;
  localparam int LANE_W       = 32;
  localparam int LANE_BITS    = $clog2(LANES);
  localparam int VEC_W        = LANES * LANE_W;
  localparam int IMG_SPACE    = NUM_PLANES * PLANE_PIXELS;
  localparam int ADDR_W       = 32;
  localparam int ROM_ADDR_W   = 128;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/vec_fifo.sv
// vec_fifo: synchronous FIFO holding captured vector words (data + last tag).
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_flush       : synchronous clear of all entries (wins over push/pop)
//   i_push/i_data : write an entry; the writer guarantees the FIFO is not full
//   i_pop         : drop the head entry; the reader guarantees it is not empty
//   o_data        : head entry, forced to zero while empty
//   o_valid       : FIFO holds at least one entry
//   o_count       : number of stored entries, used by the writer for credit
// DEPTH must be a power of two so the pointers wrap naturally.
module vec_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_valid,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      // Push and pop together (even when full) leave the count unchanged.
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/image_vector_fetch.sv
// image_vector_fetch: walks a contiguous pixel range in the image ROM, one
// 4-pixel aligned word per cycle, and streams the words out through a FIFO.
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_start             : one-cycle job request, sampled only in IDLE
//   i_abort             : cancel the running job at the next posedge
//   i_base_addr         : first pixel address (must be LANES aligned)
//   i_pixel_count       : pixels to fetch
//   o_busy              : job in progress (FETCH or DRAIN)
//   o_done / o_err      : one-cycle completion / rejection pulses
//   o_rom_addr          : registered ROM word address, zero-extended
//   i_rom_rd            : ROM read data, valid at the posedge after an issue
//   o_vec_*, i_vec_ready: output stream
//   o_state             : current FSM state, for observation
//
// Output handshake: a word transfers on a posedge where o_vec_valid and
// i_vec_ready are both high; while o_vec_valid is high and i_vec_ready low,
// o_vec_data/o_vec_last hold, and o_vec_valid only drops after a transfer or
// on abort/reset.
module image_vector_fetch
  import image_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [ADDR_W-1:0]     i_base_addr,
  input  logic [ADDR_W-1:0]     i_pixel_count,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [ROM_ADDR_W-1:0] o_rom_addr,
  input  logic [VEC_W-1:0]      i_rom_rd,
  output logic                  o_vec_valid,
  input  logic                  i_vec_ready,
  output logic [VEC_W-1:0]      o_vec_data,
  output logic                  o_vec_last,
  output fetch_state_t          o_state
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t         r_state;
  fetch_state_t         w_state_next;
  logic [ADDR_W-1:0]    r_cur;
  logic [ADDR_W-1:0]    r_words_left;
  logic [ADDR_W-1:0]    r_rom_addr;
  logic [LANE_BITS-1:0] r_rem;
  logic                 r_inflight;
  logic                 r_err;

  logic [ADDR_W:0]      w_words_ext;
  logic [ADDR_W+2:0]    w_span;
  logic [ADDR_W+2:0]    w_end;
  logic                 w_reject;
  logic                 w_accept;
  logic                 w_abort;
  logic                 w_issue;
  logic                 w_pop;
  logic                 w_cap_last;
  logic [CW:0]          w_occupancy;
  logic [CW-1:0]        w_fifo_count;
  logic [VEC_W-1:0]     w_cap_data;
  logic [VEC_W:0]       w_fifo_out;
  logic                 w_fifo_valid;

  // Job geometry, computed wide enough that no 32-bit input can overflow.
  assign w_words_ext = ({1'b0, i_pixel_count} + (ADDR_W+1)'(LANES - 1)) >> LANE_BITS;
  assign w_span      = (ADDR_W+3)'(w_words_ext) << LANE_BITS;
  assign w_end       = {3'b000, i_base_addr} + w_span;
  assign w_reject    = (i_base_addr[LANE_BITS-1:0] != '0) ||
                       (w_end > (ADDR_W+3)'(IMG_SPACE));

  assign w_accept = (r_state == ST_IDLE) && i_start && !i_abort;
  assign w_abort  = i_abort && (r_state != ST_IDLE);

  // Credit: a read may only be issued if its word is guaranteed a FIFO slot,
  // counting the word still in flight. Pops in the same cycle are not
  // credited, which keeps the check purely registered.
  assign w_occupancy = {1'b0, w_fifo_count} + (CW+1)'(r_inflight);
  assign w_issue     = (r_state == ST_FETCH) && !i_abort &&
                       (r_words_left != '0) &&
                       (w_occupancy < (CW+1)'(FIFO_DEPTH));

  assign w_pop = w_fifo_valid && i_vec_ready;

  // The word being captured is the final one once no issues remain.
  assign w_cap_last = (r_words_left == '0);

  always_comb begin
    w_cap_data = i_rom_rd;
    if (w_cap_last && (r_rem != '0)) begin
      for (int i = 0; i < LANES; i++) begin
        if (i >= int'(r_rem)) begin
          w_cap_data[LANE_W*i +: LANE_W] = '0;
        end
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && !w_reject) begin
          w_state_next = (i_pixel_count == '0) ? ST_FINISH : ST_FETCH;
        end
      end
      ST_FETCH: begin
        // Last issue is done; its capture lands on this same edge.
        if (r_words_left == '0) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave as soon as the FIFO is empty after this edge, so done
        // follows the final transfer directly.
        if ((w_fifo_count == '0) || ((w_fifo_count == CW'(1)) && w_pop)) begin
          w_state_next = ST_FINISH;
        end
      end
      ST_FINISH: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    if (w_abort) begin
      w_state_next = ST_IDLE;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_cur        <= '0;
      r_words_left <= '0;
      r_rom_addr   <= '0;
      r_rem        <= '0;
      r_inflight   <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_err   <= w_accept && w_reject;
      if (w_accept && !w_reject) begin
        r_cur        <= i_base_addr;
        r_words_left <= w_words_ext[ADDR_W-1:0];
        r_rem        <= i_pixel_count[LANE_BITS-1:0];
      end
      if (w_issue) begin
        r_rom_addr   <= r_cur;
        r_cur        <= r_cur + ADDR_W'(LANES);
        r_words_left <= r_words_left - 1'b1;
      end
      // An issue always leaves exactly one read in flight for the next edge;
      // abort drops it.
      r_inflight <= w_issue;
    end
  end

  vec_fifo #(
    .WIDTH (VEC_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (w_abort),
    .i_push  (r_inflight),
    .i_data  ({w_cap_last, w_cap_data}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_out),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_count)
  );

  assign o_busy      = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
  assign o_done      = (r_state == ST_FINISH);
  assign o_err       = r_err;
  assign o_rom_addr  = ROM_ADDR_W'(r_rom_addr);
  assign o_vec_valid = w_fifo_valid;
  assign o_vec_data  = w_fifo_out[VEC_W-1:0];
  assign o_vec_last  = w_fifo_out[VEC_W];
  assign o_state     = r_state;

endmodule

// File: tb/tb_image_vector_fetch.sv
// tb_image_vector_fetch: stimulus and scoreboard for image_vector_fetch.
// A ROM model answers reads on the falling edge; expected words come from a
// per-pixel view of the job (pixel index < count -> ROM pixel, else 0).
module tb_image_vector_fetch;
  import image_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT ----------------
  logic                  i_start = 1'b0;
  logic                  i_abort = 1'b0;
  logic [31:0]           i_base_addr = '0;
  logic [31:0]           i_pixel_count = '0;
  logic                  o_busy, o_done, o_err;
  logic [ROM_ADDR_W-1:0] o_rom_addr;
  logic [VEC_W-1:0]      i_rom_rd = '0;
  logic                  o_vec_valid;
  logic                  i_vec_ready = 1'b0;
  logic [VEC_W-1:0]      o_vec_data;
  logic                  o_vec_last;
  fetch_state_t          o_state;

  image_vector_fetch #(.FIFO_DEPTH(4)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_base_addr   (i_base_addr),
    .i_pixel_count (i_pixel_count),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_err         (o_err),
    .o_rom_addr    (o_rom_addr),
    .i_rom_rd      (i_rom_rd),
    .o_vec_valid   (o_vec_valid),
    .i_vec_ready   (i_vec_ready),
    .o_vec_data    (o_vec_data),
    .o_vec_last    (o_vec_last),
    .o_state       (o_state)
  );

  // ---------------- ROM model ----------------
  function automatic logic [31:0] pix(input logic [31:0] a);
    return (a * 32'h9E37_79B1) + 32'h0123_4567;
  endfunction

  always @(negedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      i_rom_rd[LANE_W*l +: LANE_W] = pix(o_rom_addr[31:0] + 32'(l));
    end
  end

  // ---------------- consumer ready driver ----------------
  bit ready_rand  = 1'b0;
  bit ready_force = 1'b0;
  always @(posedge clk) begin
    #2;
    i_vec_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [128:0] got, input logic [128:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [128:0] exp_q[$];
  logic [128:0] mon_e;
  logic [128:0] prev_word = '0;
  bit           prev_stall = 1'b0;
  bit           prev_abort = 1'b0;
  bit           valid_seen = 1'b0;
  int           xfer_cnt = 0, err_cnt = 0, done_cnt = 0, last_xfer_cyc = -10;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_abort = 1'b0;
    end else begin
      if (prev_stall && !prev_abort) begin
        chk("hold_valid", o_vec_valid, 1'b1);
        chk("hold_data", {o_vec_last, o_vec_data}, prev_word);
      end
      if (o_vec_valid) valid_seen = 1'b1;
      if (o_vec_valid && i_vec_ready) begin
        if (exp_q.size() != 0) mon_e = exp_q.pop_front();
        else mon_e = '1;
        chk("vec_data", o_vec_data, mon_e[127:0]);
        chk("vec_last", o_vec_last, mon_e[128]);
        xfer_cnt++;
        if (o_vec_last) last_xfer_cyc = cyc;
      end
      if (o_err)  err_cnt++;
      if (o_done) done_cnt++;
      prev_stall = o_vec_valid && !i_vec_ready;
      prev_word  = {o_vec_last, o_vec_data};
      prev_abort = i_abort;
    end
  end

  // ---------------- driver tasks ----------------
  int          job_x0, job_e0, job_d0;
  logic [31:0] job_base;

  task automatic start_job(input logic [31:0] base, input logic [31:0] cnt,
                           output bit rej, output int words);
    longint       span, p;
    logic [128:0] e;
    words = int'((longint'(cnt) + LANES - 1) / LANES);
    span  = longint'(words) * LANES;
    rej   = (base % LANES != 0) || (longint'(base) + span > longint'(IMG_SPACE));
    if (!rej) begin
      for (int w = 0; w < words; w++) begin
        for (int l = 0; l < LANES; l++) begin
          p = longint'(w) * LANES + l;
          e[LANE_W*l +: LANE_W] = (p < longint'(cnt)) ? pix(base + 32'(p)) : 32'h0;
        end
        e[128] = (w == words - 1);
        exp_q.push_back(e);
      end
    end
    job_x0 = xfer_cnt; job_e0 = err_cnt; job_d0 = done_cnt;
    valid_seen = 1'b0; job_base = base;
    @(posedge clk); #1;
    i_start = 1'b1; i_base_addr = base; i_pixel_count = cnt;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic check_reject();
    @(negedge clk);
    chk("err_pulse", o_err, 1'b1);
    chk("busy_rej", o_busy, 1'b0);
    @(negedge clk);
    chk("err_single", o_err, 1'b0);
    chk("busy_rej2", o_busy, 1'b0);
    chk("rej_no_done", 32'(done_cnt - job_d0), 32'd0);
    chk("rej_no_valid", valid_seen, 1'b0);
  endtask

  task automatic finish_job(input int words, input bit lat, input int max_cyc);
    bit got = 1'b0;
    for (int k = 0; k < max_cyc && !got; k++) begin
      @(negedge clk);
      if (lat && words >= 2) begin
        if (k == 0) begin
          chk("lat_busy", o_busy, 1'b1);
          chk("lat_valid0", o_vec_valid, 1'b0);
        end else if (k == 1) begin
          chk("lat_addr0", o_rom_addr, job_base);
          chk("lat_valid1", o_vec_valid, 1'b0);
        end else if (k == 2) begin
          chk("lat_addr1", o_rom_addr, job_base + 32'd4);
          chk("lat_valid2", o_vec_valid, 1'b1);
        end
      end
      if (o_done) begin
        got = 1'b1;
        if (words == 0) chk("done_latency", 32'(k), 32'd0);
        else chk("done_after_last", 32'(cyc), 32'(last_xfer_cyc + 1));
      end
    end
    chk("done_seen", got, 1'b1);
    @(negedge clk);
    chk("done_pulse", o_done, 1'b0);
    chk("busy_after", o_busy, 1'b0);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("word_count", 32'(xfer_cnt - job_x0), 32'(words));
    chk("job_no_err", 32'(err_cnt - job_e0), 32'd0);
    if (words == 0) chk("zero_no_valid", valid_seen, 1'b0);
  endtask

  task automatic run_job(input logic [31:0] base, input logic [31:0] cnt, input bit lat);
    bit rej;
    int words;
    start_job(base, cnt, rej, words);
    if (rej) check_reject();
    else finish_job(words, lat, 400);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"}, o_busy, 1'b0);
    chk({tag, "_done"}, o_done, 1'b0);
    chk({tag, "_err"}, o_err, 1'b0);
    chk({tag, "_rom_addr"}, o_rom_addr, '0);
    chk({tag, "_valid"}, o_vec_valid, 1'b0);
    chk({tag, "_data"}, o_vec_data, '0);
    chk({tag, "_last"}, o_vec_last, 1'b0);
    chk({tag, "_state"}, o_state, ST_IDLE);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    bit          rej;
    int          words;
    logic [31:0] b, c;

    #1 rst = 1'b1;
    #2 check_reset_values("reset");
    @(posedge clk); #1 rst = 1'b0;
    ready_force = 1'b1;
    repeat (2) @(posedge clk);

    // Basic stream with latency checks.
    run_job(32'd0, 32'd8, 1'b1);
    // Partial final word across the R0/R1 plane boundary.
    run_job(32'd9996, 32'd6, 1'b1);
    // Rejections and the zero-length job.
    run_job(32'd2, 32'd8, 1'b0);
    run_job(32'd119996, 32'd8, 1'b0);
    run_job(32'd119992, 32'd8, 1'b1);
    run_job(32'd100, 32'd0, 1'b0);

    // Backpressure: consumer stalls for 10 cycles after start.
    ready_force = 1'b0;
    @(posedge clk);
    start_job(32'd400, 32'd40, rej, words);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 5 || k == 9) begin
        chk("bp_addr_frozen", o_rom_addr, 32'd412);
        chk("bp_valid", o_vec_valid, 1'b1);
        chk("bp_state", o_state, ST_FETCH);
      end
    end
    ready_force = 1'b1;
    finish_job(words, 1'b0, 200);

    // Abort two cycles into a stalled 100-pixel job.
    ready_force = 1'b0;
    @(posedge clk);
    start_job(32'd2000, 32'd100, rej, words);
    @(posedge clk); #1 i_abort = 1'b1;
    @(posedge clk); #1 i_abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("abort_valid", o_vec_valid, 1'b0);
    chk("abort_state", o_state, ST_IDLE);
    chk("abort_busy", o_busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - job_d0), 32'd0);
    chk("abort_no_err", 32'(err_cnt - job_e0), 32'd0);
    ready_force = 1'b1;
    run_job(32'd48, 32'd16, 1'b1);

    // Asynchronous reset in the middle of a job.
    ready_rand = 1'b1;
    start_job(32'd800, 32'd100, rej, words);
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_values("midrst");
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    run_job(32'd64, 32'd13, 1'b0);

    // Randomized jobs with random backpressure.
    for (int j = 0; j < 20; j++) begin
      case ($urandom_range(0, 5))
        0:       b = 32'($urandom_range(0, 120000));
        1:       b = 32'(120000 - 4 * $urandom_range(0, 12));
        default: b = 32'(4 * $urandom_range(0, 29999));
      endcase
      c = 32'($urandom_range(0, 40));
      run_job(b, c, 1'b0);
    end
    ready_rand = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
